ruler_job_controller: RTL
=========================

Name: ruler_job_controller

Overview:
- Host-facing counterpart of the ruler search assembly.
- Receives a job as a byte stream, assembles the packed firstvalues vector, and holds the search in reset until the job is loaded.
- Releases the search, waits for done, then streams the result count and stored result rulers back to the host as bytes.
- Sits between the byte link (USB/UART FIFO) and the search assembly.

Parameters:
- NUMPOSITIONS, 5, index of the last mark; there are NUMPOSITIONS+1 values per ruler.
- VALBITS, 9, width of one mark value (PositionValueBitMaxPlus1); legal range 9..16.
- NUMRESULTS, 5, number of result rulers in the results vector (NumResultsStored).
- RST_CYCLES, 4, number of cycles search_reset is held high after the last job byte.

Ports:
- FXCLK  in  1  clock.
- RESET_IN  in  1  synchronous, active-high reset.
- rx_data  in  8  job byte from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  controller accepts a byte.
- tx_data  out  8  report byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts a byte.
- firstvalues  out  (NUMPOSITIONS+1)*VALBITS  packed start marks; value 0 in the MSBs.
- search_reset  out  1  reset to the search assembly.
- search_done  in  1  done from the search assembly.
- num_results  in  6  numResultsObserved from the search assembly.
- results  in  (NUMPOSITIONS+1)*VALBITS*NUMRESULTS  result 1 in the MSBs; within each result, mark 0 first.
- busy  out  1  high from the first job byte until the last report byte is accepted.

Behaviour:
- Clock and reset: FXCLK is the only clock. Reset is synchronous and active-high on RESET_IN.
- Reset values:
  - state=IDLE, rx_ready=1, tx_valid=0, tx_data=0.
  - firstvalues=0, search_reset=1, busy=0, all counters=0.
- Reset mid-operation: RESET_IN in any state discards the partial job or report. state becomes IDLE on the next edge. No byte is accepted on a reset cycle.
- Handshakes:
  - A byte transfers on a rising edge where valid&ready are both high.
  - tx_data and tx_valid are registered and stay stable while tx_valid=1 and tx_ready=0.
  - Back-to-back transfers run at one byte per cycle.
- Value encoding, 2 bytes per value, high byte first:
  - Received value = {hi[VALBITS-9:0], lo}. Unused upper bits of hi are ignored.
  - Transmitted hi = value>>8, zero-extended. Transmitted lo = value[7:0].
- States:
  - IDLE: rx_ready=1 and search_reset=1. The first accepted byte is stored as value 0 hi, busy rises, and the state goes to LOAD.
  - LOAD: rx_ready=1. Bytes fill values 0..NUMPOSITIONS in order; firstvalues updates as each lo byte lands. After byte 2*(NUMPOSITIONS+1) is accepted, rx_ready drops and the state goes to RSTHOLD.
  - RSTHOLD: search_reset=1 for exactly RST_CYCLES cycles counted from the cycle after the last byte, then the state goes to RUN.
  - RUN: search_reset=0 and rx_ready=0.
    - search_done is ignored in the first cycle of RUN, because the assembly's done is stale for one cycle.
    - When search_done=1 is sampled, num_results is latched as N. nrep = min(N, NUMRESULTS). The state goes to HDR.
  - HDR: tx_data = {2'b00, N}. On acceptance, go to DATA if nrep>0, else DONE.
  - DATA: for result r=1..nrep and mark i=0..NUMPOSITIONS, send hi then lo of that value, read from results at send time. This is 2*(NUMPOSITIONS+1)*nrep bytes. After the last byte is accepted, go to DONE.
  - DONE: one cycle with busy=0, tx_valid=0 and search_reset reasserted, then IDLE. firstvalues holds the last job until the next job's byte 1.
- Bytes presented on rx while rx_ready=0 are not consumed.
- N=0 produces a header-only report.
- N>NUMRESULTS reports the true N in the header but sends only NUMRESULTS rulers.
- There is no timeout. RUN persists until search_done or reset.

Test Plan:
- NUMPOSITIONS=5, VALBITS=9 throughout.
- Job load: send bytes 00 00 00 01 00 04 00 09 00 0F 00 11 -> firstvalues = {0,1,4,9,15,17}. search_reset is high exactly 4 cycles after the 12th byte, then 0. rx_ready=0 and busy=1.
- Encoding: send job with value 2 = FF 23 -> value 2 = 9'h123, other fields unaffected.
- Report with results:
  - Stimulus: search_done with num_results=2, r1={0,1,4,10,12,17}, r2={0,1,8,11,13,17}.
  - Response: tx = 02, then 00 00 00 01 00 04 00 0A 00 0C 00 11 00 00 00 01 00 08 00 0B 00 0D 00 11 (25 bytes). Then busy=0 and the state returns to IDLE.
- Empty and overflow reports:
  - num_results=0 -> single byte 00.
  - num_results=7 -> header 07 followed by exactly 60 bytes (5 rulers).
- Backpressure: hold tx_ready=0 for 10 cycles mid-DATA -> tx_data stable and no byte lost or duplicated. search_done asserted in the first RUN cycle is ignored; held done is reported one cycle later.
- Reset: assert RESET_IN after byte 5 of a job -> next cycle IDLE, busy=0, search_reset=1. A fresh 12-byte job then loads correctly from value 0.

Source files
------------

// File: rtl/ruler_job_controller.sv
// Host-side job controller for the ruler search: loads a byte-stream job into firstvalues,
// runs the search assembly, then streams the result count and stored rulers back as bytes.
module ruler_job_controller #(
  parameter int NUMPOSITIONS = 5,
  parameter int VALBITS      = 9,
  parameter int NUMRESULTS   = 5,
  parameter int RST_CYCLES   = 4
) (
  input  logic                                             FXCLK,
  input  logic                                             RESET_IN,
  input  logic [7:0]                                       rx_data,
  input  logic                                             rx_valid,
  output logic                                             rx_ready,
  output logic [7:0]                                       tx_data,
  output logic                                             tx_valid,
  input  logic                                             tx_ready,
  output logic [(NUMPOSITIONS+1)*VALBITS-1:0]              firstvalues,
  output logic                                             search_reset,
  input  logic                                             search_done,
  input  logic [5:0]                                       num_results,
  input  logic [(NUMPOSITIONS+1)*VALBITS*NUMRESULTS-1:0]   results,
  output logic                                             busy,
  output logic [2:0]                                       o_dbg_state
);

  localparam int NV = NUMPOSITIONS + 1;
  localparam int FW = NV * VALBITS;
  localparam int RW = FW * NUMRESULTS;
  localparam int HW = VALBITS - 8;
  localparam int MW = (NV > 1) ? $clog2(NV) : 1;
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [MW-1:0] LAST_MARK = MW'(NUMPOSITIONS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RSTHOLD = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_HDR     = 3'd4;
  localparam logic [2:0] ST_DATA    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  // Handshake: a byte moves on a rising FXCLK edge where valid and ready are both high;
  // tx_data/tx_valid are registers and hold steady while tx_valid=1 and tx_ready=0.

  logic [2:0]        r_state;
  logic [FW-1:0]     r_fv;
  logic [HW-1:0]     r_hi;
  logic              r_rx_lo;
  logic [MW-1:0]     r_val_idx;
  logic [CW-1:0]     r_hold_cnt;
  logic              r_run_arm;
  logic [5:0]        r_nrep;
  logic [5:0]        r_k;
  logic [MW-1:0]     r_i;
  logic              r_tx_lo;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;

  logic              w_rx_fire;
  logic              w_tx_fire;
  logic [VALBITS-1:0] w_rx_val;
  logic [5:0]        w_nk;
  logic [MW-1:0]     w_ni;
  logic              w_nlo;
  logic              w_tx_last;
  logic [VALBITS-1:0] w_val;
  logic [15:0]       w_val16;
  logic [7:0]        w_tx_byte;

  assign rx_ready     = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign search_reset = !((r_state == ST_RUN) || (r_state == ST_HDR) || (r_state == ST_DATA));
  assign busy         = !((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign firstvalues  = r_fv;
  assign o_dbg_state  = r_state;

  assign w_rx_fire = rx_valid && rx_ready;
  assign w_tx_fire = r_tx_valid && tx_ready;
  assign w_rx_val  = {r_hi, rx_data};

  // Position of the byte to present after the current one (HDR starts at result 1, mark 0, hi).
  always_comb begin
    w_nk  = r_k;
    w_ni  = r_i;
    w_nlo = 1'b0;
    if (r_state == ST_HDR) begin
      w_nk = 6'd0;
      w_ni = '0;
    end else if (!r_tx_lo) begin
      w_nlo = 1'b1;
    end else if (r_i == LAST_MARK) begin
      w_nk = r_k + 6'd1;
      w_ni = '0;
    end else begin
      w_ni = r_i + MW'(1);
    end
  end

  assign w_tx_last = (r_k == r_nrep - 6'd1) && (r_i == LAST_MARK) && r_tx_lo;

  always_comb begin
    w_val = '0;
    for (int k = 0; k < NUMRESULTS; k++) begin
      for (int i = 0; i < NV; i++) begin
        if ((w_nk == 6'(k)) && (w_ni == MW'(i))) begin
          w_val = results[RW-1-(k*NV+i)*VALBITS -: VALBITS];
        end
      end
    end
  end

  assign w_val16   = 16'(w_val);
  assign w_tx_byte = w_nlo ? w_val16[7:0] : w_val16[15:8];

  always_ff @(posedge FXCLK) begin
    if (RESET_IN) begin
      r_state    <= ST_IDLE;
      r_fv       <= '0;
      r_hi       <= '0;
      r_rx_lo    <= 1'b0;
      r_val_idx  <= '0;
      r_hold_cnt <= '0;
      r_run_arm  <= 1'b0;
      r_nrep     <= '0;
      r_k        <= '0;
      r_i        <= '0;
      r_tx_lo    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rx_fire) begin
            r_fv      <= '0;
            r_hi      <= rx_data[HW-1:0];
            r_rx_lo   <= 1'b1;
            r_val_idx <= '0;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_rx_fire) begin
            if (!r_rx_lo) begin
              r_hi    <= rx_data[HW-1:0];
              r_rx_lo <= 1'b1;
            end else begin
              for (int j = 0; j < NV; j++) begin
                if (r_val_idx == MW'(j)) r_fv[FW-1-j*VALBITS -: VALBITS] <= w_rx_val;
              end
              r_rx_lo <= 1'b0;
              if (r_val_idx == LAST_MARK) begin
                r_hold_cnt <= '0;
                r_state    <= ST_RSTHOLD;
              end else begin
                r_val_idx <= r_val_idx + MW'(1);
              end
            end
          end
        end
        ST_RSTHOLD: begin
          if (r_hold_cnt == CW'(RST_CYCLES - 1)) begin
            r_run_arm <= 1'b0;
            r_state   <= ST_RUN;
          end else begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          // The assembly's done output is stale for the first cycle out of reset.
          r_run_arm <= 1'b1;
          if (r_run_arm && search_done) begin
            r_nrep     <= (num_results > 6'(NUMRESULTS)) ? 6'(NUMRESULTS) : num_results;
            r_tx_data  <= {2'b00, num_results};
            r_tx_valid <= 1'b1;
            r_state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_tx_fire) begin
            if (r_nrep != 6'd0) begin
              r_k       <= w_nk;
              r_i       <= w_ni;
              r_tx_lo   <= w_nlo;
              r_tx_data <= w_tx_byte;
              r_state   <= ST_DATA;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_DONE;
            end
          end
        end
        ST_DATA: begin
          if (w_tx_fire) begin
            if (w_tx_last) begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_DONE;
            end else begin
              r_k       <= w_nk;
              r_i       <= w_ni;
              r_tx_lo   <= w_nlo;
              r_tx_data <= w_tx_byte;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
